fp_stim_gen: RTL and testbench



---
 rtl/fp_stim_gen_if.sv | 33 +++
 rtl/fp_stim_gen.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_fp_stim_gen.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_stim_gen_if.sv
// Operand-pair stream between the stimulus generator and the adder under test.
//   out_valid / out_ready : stream handshake (pair transfers when both are high)
//   a, b                  : operands, WIDTH bits each
//   operation_select      : 0 add, 1 sub
//   index                 : beat number of the presented pair
interface fp_stim_gen_if #(
   parameter int unsigned WIDTH = 32
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             operation_select;
   logic [15:0]      index;

   modport master (
      output out_valid,
      output a,
      output b,
      output operation_select,
      output index,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  a,
      input  b,
      input  operation_select,
      input  index,
      output out_ready
   );
endinterface

// File: rtl/fp_stim_gen.sv
// Operand-pair generator for the floating-point add/sub datapath.
// A run is launched by start and emits exactly count pairs on the stream
// interface, in zero, fixed, random, special-value, ordered or narrow mode.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : launch a run (sampled only when idle)
//   mode, op_cfg, count   : run configuration, latched on start
//   value_a, value_b      : operands for the fixed mode, latched on start
//   bus (master)          : out_valid/out_ready, a, b, operation_select, index
//   busy                  : high while a run is emitting pairs
//   done                  : one-cycle pulse at the end of a run
module fp_stim_gen #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned EXP_BITS  = 8,
   parameter int unsigned MANT_BITS = 23,
   parameter logic [31:0] SEED      = 32'h0000_0001
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2:0]           mode,
   input  logic [1:0]           op_cfg,
   input  logic [15:0]          count,
   input  logic [WIDTH-1:0]     value_a,
   input  logic [WIDTH-1:0]     value_b,
   fp_stim_gen_if.master        bus,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned RND_BITS  = 2 * WIDTH + 1;
   localparam int unsigned RNG_WORDS = (RND_BITS + 31) / 32;
   localparam logic [3:0]  SPEC_LAST = 4'd11;

   localparam logic [2:0] MODE_ZERO    = 3'd0;
   localparam logic [2:0] MODE_FIXED   = 3'd1;
   localparam logic [2:0] MODE_RANDOM  = 3'd2;
   localparam logic [2:0] MODE_SPECIAL = 3'd3;
   localparam logic [2:0] MODE_A_GT_B  = 3'd4;
   localparam logic [2:0] MODE_A_LT_B  = 3'd5;
   localparam logic [2:0] MODE_NARROW  = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [31:0]      rng_q;
   logic [2:0]       mode_q;
   logic [1:0]       op_cfg_q;
   logic [15:0]      count_q;
   logic [WIDTH-1:0] value_a_q;
   logic [WIDTH-1:0] value_b_q;
   logic [3:0]       spec_lo_q;
   logic [3:0]       spec_hi_q;

   logic             valid_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             op_q;
   logic [15:0]      index_q;

   logic             gen_idle;
   logic [31:0]      rng_src;
   logic [31:0]      words [RNG_WORDS+1];
   logic [RND_BITS-1:0] rnd;

   logic [2:0]       g_mode;
   logic [1:0]       g_op_cfg;
   logic [WIDTH-1:0] g_va;
   logic [WIDTH-1:0] g_vb;
   logic [3:0]       g_lo;
   logic [3:0]       g_hi;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] max_v;
   logic [WIDTH-1:0] min_v;
   logic [WIDTH-1:0] gen_a;
   logic [WIDTH-1:0] gen_b;
   logic             gen_op;
   logic             handshake;

   function automatic logic [31:0] xorshift32(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   // Special-value table entry k for the configured format.
   function automatic logic [WIDTH-1:0] special_val(input logic [3:0] k);
      logic                 s;
      logic [EXP_BITS-1:0]  e;
      logic [MANT_BITS-1:0] m;
      s = 1'b0;
      e = '0;
      m = '0;
      case (k)
         4'd1:  s = 1'b1;
         4'd2:  e = '1;
         4'd3:  begin s = 1'b1; e = '1; end
         4'd4:  begin e = '1; m[MANT_BITS-1] = 1'b1; end
         4'd5:  begin e = '1; e[0] = 1'b0; m = '1; end
         4'd6:  e = EXP_BITS'(1);
         4'd7:  m = MANT_BITS'(1);
         4'd8:  begin s = 1'b1; e = '1; e[0] = 1'b0; m = '1; end
         4'd9:  begin s = 1'b1; e = EXP_BITS'(1); end
         4'd10: begin s = 1'b1; m = MANT_BITS'(1); end
         4'd11: begin e = '1; e[EXP_BITS-1] = 1'b0; end
         default: s = 1'b0;
      endcase
      return {s, e, m};
   endfunction

   // Positive value with exponent just above the bias region and a 3-bit mantissa top.
   function automatic logic [WIDTH-1:0] narrow_val(input logic [4:0] r);
      logic [EXP_BITS-1:0]  e;
      logic [MANT_BITS-1:0] m;
      e = '0;
      e[EXP_BITS-1] = 1'b1;
      e[1:0] = r[1:0];
      m = '0;
      m[MANT_BITS-1 -: 3] = r[4:2];
      return {1'b0, e, m};
   endfunction

   assign handshake = valid_q && bus.out_ready;
   assign gen_idle  = (state == ST_IDLE);

   // Idle generation computes the first beat straight from the seed.
   assign rng_src  = gen_idle ? SEED : rng_q;
   assign words[0] = rng_src;

   // Chain of xorshift words for one beat; R is built from words 1..K.
   for (genvar gi = 0; gi < RNG_WORDS; gi++) begin : g_words
      assign words[gi+1] = xorshift32(words[gi]);
   end

   for (genvar gb = 0; gb < RND_BITS; gb++) begin : g_rnd
      assign rnd[gb] = words[gb/32 + 1][gb%32];
   end

   // Next-pair generator: live inputs when idle, latched config during a run.
   always_comb begin
      g_mode   = gen_idle ? mode     : mode_q;
      g_op_cfg = gen_idle ? op_cfg   : op_cfg_q;
      g_va     = gen_idle ? value_a  : value_a_q;
      g_vb     = gen_idle ? value_b  : value_b_q;
      g_lo     = 4'd0;
      g_hi     = 4'd0;
      ra       = rnd[WIDTH-1:0];
      rb       = rnd[2*WIDTH-1:WIDTH];
      max_v    = ra;
      min_v    = rb;
      gen_a    = '0;
      gen_b    = '0;
      gen_op   = 1'b0;

      if (!gen_idle) begin
         if (spec_lo_q == SPEC_LAST) begin
            g_lo = 4'd0;
            g_hi = (spec_hi_q == SPEC_LAST) ? 4'd0 : spec_hi_q + 4'd1;
         end else begin
            g_lo = spec_lo_q + 4'd1;
            g_hi = spec_hi_q;
         end
      end

      // Equal draws are split so the ordered modes stay strict.
      if (ra > rb) begin
         max_v = ra;
         min_v = rb;
      end else if (ra < rb) begin
         max_v = rb;
         min_v = ra;
      end else begin
         max_v = ra | WIDTH'(1);
         min_v = ra & ~WIDTH'(1);
      end

      case (g_mode)
         MODE_FIXED:   begin gen_a = g_va;  gen_b = g_vb;  end
         MODE_RANDOM:  begin gen_a = ra;    gen_b = rb;    end
         MODE_SPECIAL: begin gen_a = special_val(g_hi); gen_b = special_val(g_lo); end
         MODE_A_GT_B:  begin gen_a = max_v; gen_b = min_v; end
         MODE_A_LT_B:  begin gen_a = min_v; gen_b = max_v; end
         MODE_NARROW:  begin
            gen_a = narrow_val(rnd[4:0]);
            gen_b = narrow_val(rnd[WIDTH+4:WIDTH]);
         end
         default:      begin gen_a = '0;    gen_b = '0;    end
      endcase

      case (g_op_cfg)
         2'd0:    gen_op = 1'b0;
         2'd1:    gen_op = 1'b1;
         2'd2:    gen_op = gen_idle ? 1'b0 : ~op_q;
         default: gen_op = rnd[2*WIDTH];
      endcase
   end

   // Run control FSM with registered stream outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rng_q     <= SEED;
         mode_q    <= '0;
         op_cfg_q  <= '0;
         count_q   <= '0;
         value_a_q <= '0;
         value_b_q <= '0;
         spec_lo_q <= '0;
         spec_hi_q <= '0;
         valid_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 1'b0;
         index_q   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mode_q    <= mode;
                  op_cfg_q  <= op_cfg;
                  count_q   <= count;
                  value_a_q <= value_a;
                  value_b_q <= value_b;
                  rng_q     <= SEED;
                  if (count == 16'd0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= ST_RUN;
                     busy      <= 1'b1;
                     valid_q   <= 1'b1;
                     a_q       <= gen_a;
                     b_q       <= gen_b;
                     op_q      <= gen_op;
                     index_q   <= 16'd0;
                     spec_lo_q <= g_lo;
                     spec_hi_q <= g_hi;
                     rng_q     <= words[RNG_WORDS];
                  end
               end
            end
            ST_RUN: begin
               if (handshake) begin
                  if (index_q == count_q - 16'd1) begin
                     state   <= ST_DONE;
                     valid_q <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     a_q       <= gen_a;
                     b_q       <= gen_b;
                     op_q      <= gen_op;
                     index_q   <= index_q + 16'd1;
                     spec_lo_q <= g_lo;
                     spec_hi_q <= g_hi;
                     rng_q     <= words[RNG_WORDS];
                  end
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.out_valid        = valid_q;
   assign bus.a                = a_q;
   assign bus.b                = b_q;
   assign bus.operation_select = op_q;
   assign bus.index            = index_q;

endmodule

// File: tb/tb_fp_stim_gen.sv
// Self-checking bench for fp_stim_gen (binary32 format, SEED=1).
module tb_fp_stim_gen;

   localparam int unsigned W = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  mode;
   logic [1:0]  op_cfg;
   logic [15:0] count;
   logic [31:0] value_a;
   logic [31:0] value_b;
   logic        busy;
   logic        done;

   fp_stim_gen_if #(.WIDTH(W)) bus ();

   fp_stim_gen #(
      .WIDTH(W), .EXP_BITS(8), .MANT_BITS(23), .SEED(32'h0000_0001)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .op_cfg(op_cfg),
      .count(count), .value_a(value_a), .value_b(value_b),
      .bus(bus), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [15:0] idx;
   } beat_t;

   typedef struct {
      logic [2:0]  md;
      logic [1:0]  oc;
      int          cnt;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] ea;
      logic [31:0] eb;
      logic        eop;
   } vec_t;

   beat_t       sb_q[$];
   beat_t       mon_e;
   int          tests = 0;
   int          fails = 0;
   int          got_beats = 0;
   logic [15:0] last_idx = '0;
   logic [3:0]  op_hist = '0;
   logic [2:0]  prop_mode = '0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] xs(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   function automatic logic [31:0] tb_special(input int k);
      case (k)
         0:  return 32'h0000_0000;
         1:  return 32'h8000_0000;
         2:  return 32'h7F80_0000;
         3:  return 32'hFF80_0000;
         4:  return 32'h7FC0_0000;
         5:  return 32'h7F7F_FFFF;
         6:  return 32'h0080_0000;
         7:  return 32'h0000_0001;
         8:  return 32'hFF7F_FFFF;
         9:  return 32'h8080_0000;
         10: return 32'h8000_0001;
         default: return 32'h3F80_0000;
      endcase
   endfunction

   function automatic logic [31:0] tb_narrow(input logic [4:0] r);
      return {1'b0, 8'h80 | {6'b0, r[1:0]}, r[4:2], 20'b0};
   endfunction

   // Reference model: push the whole expected run into the scoreboard.
   task automatic push_run(input logic [2:0] md, input logic [1:0] oc, input int cnt,
                           input logic [31:0] va, input logic [31:0] vb);
      logic [31:0] st, w1, w2, w3, hi, lo;
      logic        alt;
      beat_t       e;
      st  = 32'h1;
      alt = 1'b0;
      for (int k = 0; k < cnt; k++) begin
         w1 = xs(st);
         w2 = xs(w1);
         w3 = xs(w2);
         if (w1 > w2)      begin hi = w1; lo = w2; end
         else if (w1 < w2) begin hi = w2; lo = w1; end
         else              begin hi = w1 | 32'h1; lo = w1 & ~32'h1; end
         case (md)
            3'd1:    begin e.a = va; e.b = vb; end
            3'd2:    begin e.a = w1; e.b = w2; end
            3'd3:    begin e.a = tb_special((k % 144) / 12); e.b = tb_special(k % 12); end
            3'd4:    begin e.a = hi; e.b = lo; end
            3'd5:    begin e.a = lo; e.b = hi; end
            3'd6:    begin e.a = tb_narrow(w1[4:0]); e.b = tb_narrow(w2[4:0]); end
            default: begin e.a = 32'h0; e.b = 32'h0; end
         endcase
         case (oc)
            2'd0:    e.op = 1'b0;
            2'd1:    e.op = 1'b1;
            2'd2:    e.op = alt;
            default: e.op = w3[0];
         endcase
         e.idx = 16'(k);
         sb_q.push_back(e);
         st  = w3;
         alt = ~alt;
      end
   endtask

   // Scoreboard consumer: compare every handshaken pair.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         got_beats++;
         last_idx = bus.index;
         op_hist  = {op_hist[2:0], bus.operation_select};
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL beat_unexpected: got index %0d expected no beat", bus.index);
         end else begin
            mon_e = sb_q.pop_front();
            check("beat", {15'b0, bus.a, bus.b, bus.operation_select, bus.index},
                  {15'b0, mon_e.a, mon_e.b, mon_e.op, mon_e.idx});
         end
         case (prop_mode)
            3'd4: check("a_gt_b", 96'(bus.a > bus.b), 96'd1);
            3'd5: check("a_lt_b", 96'(bus.a < bus.b), 96'd1);
            3'd6: check("narrow_range",
                        96'(!bus.a[31] && !bus.b[31] &&
                            bus.a[30:23] >= 8'h80 && bus.a[30:23] <= 8'h83 &&
                            bus.b[30:23] >= 8'h80 && bus.b[30:23] <= 8'h83 &&
                            bus.a[19:0] == 20'h0 && bus.b[19:0] == 20'h0), 96'd1);
            default: ;
         endcase
      end
   end

   task automatic launch(input logic [2:0] md, input logic [1:0] oc, input int cnt,
                         input logic [31:0] va, input logic [31:0] vb);
      @(posedge clk); #1;
      mode    = md;
      op_cfg  = oc;
      count   = 16'(cnt);
      value_a = va;
      value_b = vb;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      // Scramble inputs: the run must use the latched copy.
      mode    = ~md;
      op_cfg  = ~oc;
      count   = 16'(cnt + 7);
      value_a = ~va;
      value_b = ~vb;
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      while (!done && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   vec_t tbl[9];
   int   n;
   int   b0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{3'd2, 2'd0, 2,    32'h0, 32'h0, 32'h0004_2021, 32'h0408_0601, 1'b0};
      tbl[1] = '{3'd0, 2'd1, 5,    32'h0, 32'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
      tbl[2] = '{3'd1, 2'd2, 6,    32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0};
      tbl[3] = '{3'd3, 2'd0, 14,   32'h0, 32'h0, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[4] = '{3'd7, 2'd3, 3,    32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 32'h0000_0000, 1'b1};
      tbl[5] = '{3'd2, 2'd3, 4,    32'h0, 32'h0, 32'h0004_2021, 32'h0408_0601, 1'b1};
      tbl[6] = '{3'd4, 2'd0, 1000, 32'h0, 32'h0, 32'h0408_0601, 32'h0004_2021, 1'b0};
      tbl[7] = '{3'd5, 2'd0, 1000, 32'h0, 32'h0, 32'h0004_2021, 32'h0408_0601, 1'b0};
      tbl[8] = '{3'd6, 2'd1, 1000, 32'h0, 32'h0, 32'h4080_0000, 32'h4080_0000, 1'b1};

      rst = 1'b1; start = 1'b0; mode = '0; op_cfg = '0; count = '0;
      value_a = '0; value_b = '0; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            {bus.out_valid, bus.a, bus.b, bus.operation_select, bus.index, busy, done}, '0);
      rst = 1'b0;
      bus.out_ready = 1'b1;

      // Table-driven runs with out_ready held high.
      for (int i = 0; i < 9; i++) begin
         prop_mode = tbl[i].md;
         push_run(tbl[i].md, tbl[i].oc, tbl[i].cnt, tbl[i].va, tbl[i].vb);
         b0 = got_beats;
         launch(tbl[i].md, tbl[i].oc, tbl[i].cnt, tbl[i].va, tbl[i].vb);
         check("first_beat", {bus.out_valid, busy, bus.a, bus.b, bus.operation_select},
               {1'b1, 1'b1, tbl[i].ea, tbl[i].eb, tbl[i].eop});
         wait_done(4000, n);
         check("done_latency", 96'(n), 96'(tbl[i].cnt));
         check("beat_count", 96'(got_beats - b0), 96'(tbl[i].cnt));
         check("last_index", 96'(last_idx), 96'(tbl[i].cnt - 1));
         check("sb_empty", 96'(sb_q.size()), 96'd0);
         @(posedge clk); #1;
         check("done_pulse_end", {bus.out_valid, busy, done}, 96'd0);
      end
      prop_mode = 3'd0;

      // Stall on beat 1: outputs held while out_ready is low.
      push_run(3'd1, 2'd2, 4, 32'h3F80_0000, 32'h4000_0000);
      launch(3'd1, 2'd2, 4, 32'h3F80_0000, 32'h4000_0000);
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      repeat (3) begin
         check("stall_hold",
               {bus.out_valid, bus.a, bus.b, bus.operation_select, bus.index},
               {1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1, 16'd1});
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      wait_done(50, n);
      check("alt_op_sequence", 96'(op_hist), 96'(4'b0101));
      check("stall_sb_empty", 96'(sb_q.size()), 96'd0);
      @(posedge clk); #1;

      // Zero-count run: done only, no beats.
      b0 = got_beats;
      launch(3'd2, 2'd0, 0, 32'h0, 32'h0);
      check("count0_first", {bus.out_valid, busy, done}, 96'(3'b001));
      @(posedge clk); #1;
      check("count0_next", {bus.out_valid, busy, done}, 96'd0);
      check("count0_beats", 96'(got_beats - b0), 96'd0);

      // Start pulse during a run is ignored.
      push_run(3'd0, 2'd0, 20, 32'h0, 32'h0);
      b0 = got_beats;
      launch(3'd0, 2'd0, 20, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      mode = 3'd1; count = 16'd3; value_a = 32'hDEAD_BEEF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(100, n);
      check("busy_start_beats", 96'(got_beats - b0), 96'd20);
      check("busy_start_sb", 96'(sb_q.size()), 96'd0);
      @(posedge clk); #1;

      // Reset mid-run at beat 5 of 10, then replay from the seed.
      push_run(3'd2, 2'd0, 10, 32'h0, 32'h0);
      launch(3'd2, 2'd0, 10, 32'h0, 32'h0);
      n = 0;
      while (!(bus.out_valid && bus.index == 16'd5) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("reached_beat5", 96'(bus.index), 96'd5);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrun_reset_outputs",
            {bus.out_valid, bus.a, bus.b, bus.operation_select, bus.index, busy, done}, '0);
      rst = 1'b0;
      sb_q.delete();
      n = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done) n++;
      end
      check("no_done_after_reset", 96'(n), 96'd0);
      push_run(3'd2, 2'd0, 3, 32'h0, 32'h0);
      launch(3'd2, 2'd0, 3, 32'h0, 32'h0);
      check("replay_first", {bus.a, bus.b}, {32'h0004_2021, 32'h0408_0601});
      wait_done(50, n);
      check("replay_latency", 96'(n), 96'd3);
      check("replay_sb", 96'(sb_q.size()), 96'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
